// File: rtl/delay_pkg.sv
// delay_pkg: shared types and defaults for the multi-channel delay line
package delay_pkg;
  localparam int DELAY_WIDTH_DEFAULT    = 24;
  localparam int DELAY_MAXLEN_DEFAULT   = 2048;
  localparam int DELAY_CHANNELS_DEFAULT = 4;
  // Channel index width; a single channel still gets one bit so ports never collapse to zero width
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef logic [DELAY_WIDTH_DEFAULT-1:0] sample_t;
  typedef logic [clog2_min1(DELAY_CHANNELS_DEFAULT)-1:0] ch_t;
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port, read-before-write
module sdp_ram #(
  parameter int DEPTH = 8192,
  parameter int DW    = 24,
  parameter int AWID  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AWID-1:0] waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            re,
  input  logic [AWID-1:0] raddr,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [DEPTH];
  // Both ports update on the same edge; a colliding read returns the old word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/multi_delay_line.sv
// multi_delay_line: per-channel circular-buffer sample delay sharing one RAM
module multi_delay_line
  import delay_pkg::*;
#(
  parameter int WIDTH    = DELAY_WIDTH_DEFAULT,
  parameter int MAXLEN   = DELAY_MAXLEN_DEFAULT,
  parameter int CHANNELS = DELAY_CHANNELS_DEFAULT,
  parameter int CH_W     = clog2_min1(CHANNELS),
  parameter int AW       = $clog2(MAXLEN)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             len_we,
  input  logic [CH_W-1:0]  len_ch,
  input  logic [AW:0]      len_val,
  input  logic             clear,
  input  logic [CH_W-1:0]  clear_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_sample
);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(MAXLEN);

  logic             adv, accept, clr_hit;
  logic [AW-1:0]    wptr [CHANNELS];
  logic [AW:0]      fill [CHANNELS];
  logic [AW:0]      len  [CHANNELS];
  logic [AW-1:0]    cur_wptr, rd_ptr;
  logic [AW:0]      cur_fill, cur_len, len_clamped;
  logic [WIDTH-1:0] rdata;
  logic             s1_valid, s1_bypass, s1_zero;
  logic [CH_W-1:0]  s1_ch;
  logic [WIDTH-1:0] s1_sample;

  // Handshake, current-channel lookup and read address (wptr - len wraps modulo MAXLEN)
  always_comb begin
    adv         = !out_valid || out_ready;
    in_ready    = adv;
    accept      = in_valid && adv;
    cur_wptr    = wptr[in_ch];
    cur_fill    = fill[in_ch];
    cur_len     = len[in_ch];
    rd_ptr      = cur_wptr - cur_len[AW-1:0];
    clr_hit     = clear && (clear_ch == in_ch);
    len_clamped = (len_val > LEN_MAX) ? LEN_MAX : len_val;
  end

  // Per-channel pointer, fill and length registers; clear overrides an accept on the same channel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr[c] <= '0;
        fill[c] <= '0;
        len[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (len_we && len_ch == CH_W'(c)) len[c] <= len_clamped;
        if (clear && clear_ch == CH_W'(c)) begin
          wptr[c] <= '0;
          fill[c] <= '0;
        end else if (accept && in_ch == CH_W'(c)) begin
          wptr[c] <= wptr[c] + 1'b1;
          fill[c] <= (fill[c] == LEN_MAX) ? fill[c] : fill[c] + 1'b1;
        end
      end
    end
  end

  // Read is gated by accept so the RAM output holds while the pipeline is stalled
  sdp_ram #(
    .DEPTH(CHANNELS * MAXLEN),
    .DW   (WIDTH),
    .AWID (CH_W + AW)
  ) u_ram (
    .clk  (clk),
    .we   (accept),
    .waddr({in_ch, cur_wptr}),
    .wdata(in_sample),
    .re   (accept),
    .raddr({in_ch, rd_ptr}),
    .rdata(rdata)
  );

  // Stage 1: capture the sample and its selection flags alongside the RAM read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_ch     <= '0;
      s1_sample <= '0;
      s1_bypass <= 1'b0;
      s1_zero   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= accept;
      s1_ch     <= in_ch;
      s1_sample <= in_sample;
      s1_bypass <= (cur_len == '0);
      s1_zero   <= clr_hit || (cur_fill < cur_len);
    end
  end

  // Stage 2: pick zero (unfilled or cleared), bypass (len 0) or the RAM word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sample <= '0;
    end else if (adv) begin
      out_valid  <= s1_valid;
      out_ch     <= s1_ch;
      out_sample <= s1_zero ? '0 : s1_bypass ? s1_sample : rdata;
    end
  end
endmodule

// File: tb/tb_multi_delay_line.sv
// tb_multi_delay_line: directed checks of delay, wrap, interleave, stall, clear and reset
module tb_multi_delay_line;
  localparam int WIDTH = 24, MAXLEN = 2048, CH_W = 2, AW = 11;

  logic             clk = 0, rstn = 1;
  logic             in_valid = 0, in_ready;
  logic [CH_W-1:0]  in_ch = 0;
  logic [WIDTH-1:0] in_sample = 0;
  logic             len_we = 0;
  logic [CH_W-1:0]  len_ch = 0;
  logic [AW:0]      len_val = 0;
  logic             clear = 0;
  logic [CH_W-1:0]  clear_ch = 0;
  logic             out_valid, out_ready = 1;
  logic [CH_W-1:0]  out_ch;
  logic [WIDTH-1:0] out_sample;

  typedef struct {int ch; int s; int c;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, errors = 0, checks = 0;
  bit chk_lat = 1;

  multi_delay_line dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_sample(in_sample), .len_we(len_we), .len_ch(len_ch), .len_val(len_val),
    .clear(clear), .clear_ch(clear_ch), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_sample(out_sample)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Scoreboard: every handshaked output is matched in order against the expected queue
  always @(negedge clk) begin
    #2;
    if (rstn && out_valid && out_ready) begin
      chk("out_expected", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_ch", 64'(out_ch), 64'(e.ch));
        chk("out_sample", 64'(out_sample), 64'(e.s));
        if (chk_lat) chk("latency", 64'(cyc - e.c), 64'(2));
      end
    end
  end

  task automatic send(input int ch, input int s, input int want);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_ch = CH_W'(ch); in_sample = WIDTH'(s);
    #1;
    while (!in_ready && n < 100) begin @(negedge clk); #1; n++; end
    chk("in_ready_wait", 64'(in_ready), 64'(1));
    q.push_back('{ch, want, cyc});
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (q.size() != 0 && n < 50) begin @(negedge clk); #3; n++; end
    chk("drain", 64'(q.size()), 64'(0));
  endtask

  task automatic set_len(input int ch, input int v);
    @(negedge clk);
    len_we = 1; len_ch = CH_W'(ch); len_val = (AW+1)'(v);
    @(negedge clk);
    len_we = 0;
  endtask

  task automatic flush(input int ch);
    @(negedge clk);
    clear = 1; clear_ch = CH_W'(ch);
    @(negedge clk);
    clear = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rstn = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_ch", 64'(out_ch), 64'(0));
    chk("rst_out_sample", 64'(out_sample), 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'(1));

    // len 4 on ch0: four zeros then the stream delayed by four
    set_len(0, 4);
    for (int k = 1; k <= 10; k++) send(0, k, (k <= 4) ? 0 : k - 4);
    drain();

    // len 0: bypass with the same latency
    set_len(0, 0);
    send(0, 7, 7);
    send(0, 8, 8);
    drain();

    // over-range length clamps to MAXLEN; wrap reads the word written MAXLEN accepts ago
    set_len(1, 3000);
    for (int k = 0; k < MAXLEN + 3; k++) send(1, k, (k < MAXLEN) ? 0 : k - MAXLEN);
    drain();

    // interleaved channels with independent lengths
    flush(0);
    flush(1);
    set_len(0, 2);
    set_len(1, 3);
    for (int k = 0; k < 4; k++) begin
      send(0, 100 + k, (k < 2) ? 0 : 98 + k);
      send(1, 200 + k, (k < 3) ? 0 : 197 + k);
    end
    drain();

    // stall mid-stream on ch3 (len 1): outputs frozen, input blocked, nothing lost
    chk_lat = 0;
    set_len(3, 1);
    send(3, 50, 0);
    send(3, 51, 50);
    send(3, 52, 51);
    send(3, 53, 52);
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_ch = 3; in_sample = 54;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
      chk("stall_out_ch", 64'(out_ch), 64'(3));
      chk("stall_out_sample", 64'(out_sample), 64'(51));
      @(negedge clk);
    end
    out_ready = 1; in_valid = 0;
    for (int k = 54; k <= 57; k++) send(3, k, k - 1);
    drain();
    chk_lat = 1;

    // clear ch2 after filling: old contents are hidden
    set_len(2, 3);
    for (int k = 1; k <= 5; k++) send(2, k, (k <= 3) ? 0 : k - 3);
    drain();
    flush(2);
    for (int k = 0; k < 4; k++) send(2, 9, (k < 3) ? 0 : 9);
    drain();

    // asynchronous reset mid-stream
    send(2, 20, 9);
    send(2, 21, 9);
    @(negedge clk);
    in_valid = 0;
    #1 chk("pre_rst_out_valid", 64'(out_valid), 64'(1));
    #2 rstn = 0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_out_sample", 64'(out_sample), 64'(0));
    q.delete();
    repeat (2) @(negedge clk);
    rstn = 1;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    set_len(2, 3);
    for (int k = 11; k <= 14; k++) send(2, k, (k < 14) ? 0 : 11);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_delay_line.md
Name: multi_delay_line

Overview:
- Multi-channel, variable-length sample delay for the reverb/comb path.
- Replaces per-tap shift-register queues with a single RAM holding one circular buffer per channel.
- Channels are time-multiplexed over one valid/ready input stream; delay length is programmable per channel at run time.
- Sits between the voice mixer and the comb/allpass filters; output stream carries channel tag and delayed sample.

Parameters:
WIDTH, 24, sample width in bits (two's complement, passed through untouched)
MAXLEN, 2048, max delay per channel in samples; power of two, >= 4
CHANNELS, 4, number of independent delay lines; power of two, >= 1
CH_W, $clog2(CHANNELS) (min 1), channel index width, derived, do not override
AW, $clog2(MAXLEN), per-channel address width, derived

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
in_valid  in  1  input sample present
in_ready  out  1  block can accept input this cycle
in_ch  in  CH_W  channel of input sample
in_sample  in  WIDTH  input sample
len_we  in  1  write delay length register
len_ch  in  CH_W  channel for len write
len_val  in  AW+1  delay in samples, 0..MAXLEN
clear  in  1  pulse: flush channel clear_ch
clear_ch  in  CH_W  channel to flush
out_valid  out  1  delayed sample present
out_ready  in  1  downstream accepts
out_ch  out  CH_W  channel of output sample
out_sample  out  WIDTH  delayed sample

Behaviour:
- Reset (async, rstn=0):
  - out_valid=0, out_ch=0, out_sample=0, in_ready=1 after release.
  - All wptr=0, fill=0, len=0.
  - RAM contents are not reset.
- Storage: RAM of CHANNELS*MAXLEN words, address {ch, ptr}. Per channel: wptr[AW], fill counter[AW+1] saturating at MAXLEN, len register[AW+1].
- Advance condition: adv = !out_valid || out_ready. in_ready = adv; accept = in_valid && in_ready.
- Pipeline, two stages, both enabled by adv:
  - S1 (accept cycle): compute raddr = {ch, wptr[ch]-len[ch]} mod MAXLEN; issue synchronous RAM read; write in_sample at {ch, wptr[ch]}.
  - RAM is read-before-write, so len=MAXLEN returns the sample written MAXLEN accepts ago.
  - Increment wptr[ch] (wraps at MAXLEN); fill[ch] += 1, saturating.
  - S2: register the result to out_*.
- Latency: a sample accepted at cycle t appears with out_valid=1 at t+2, assuming no stall.
- Stall: out_valid=1 && out_ready=0 holds out_* stable and freezes S1 (RAM read-enable=adv). No sample is lost or duplicated.
- Output value selection:
  - len=0: out_sample = in_sample of the same accept (bypass through pipeline, same latency).
  - fill (before increment) < len: out_sample=0. This hides stale RAM content after reset or clear.
  - Otherwise: the RAM word read.
- Length writes:
  - len_val > MAXLEN clamps to MAXLEN.
  - A write takes effect on the next accept for that channel.
  - len_we and accept on the same channel in the same cycle: the sample uses the old len.
  - Shrinking len causes an immediate jump; no interpolation.
- Clear:
  - Sets wptr[clear_ch]=0 and fill[clear_ch]=0; len is retained.
  - Clear and accept on the same channel in the same cycle: clear wins for the pointers. The sample is still written at the old wptr and its output is forced to 0; the next accept writes at address 0.
  - Samples already in S2 are unaffected.
- Channels are fully independent; any interleave order is legal, including back-to-back same-channel accepts.
- Width: pointer arithmetic is modulo MAXLEN (AW bits); the fill comparison is AW+1 bits unsigned.

Decomposition:
- Shared package `delay_pkg`: typedef `sample_t` (logic [WIDTH-1:0] at the default), `ch_t`, and constant `DELAY_MAXLEN_DEFAULT`.
- One sub-module `sdp_ram`: simple dual-port, one write and one synchronous read port, read-before-write, parametrised DEPTH/WIDTH, with read enable. Inference-friendly for BRAM.
- All control logic lives in `multi_delay_line`.

Test Plan:
- Reset, len[0]=4, feed ch0 samples 1,2,3,...,10 continuously, out_ready=1 -> outputs 0,0,0,0,1,2,3,4,5,6; each output arrives 2 cycles after its accept.
- len[0]=0, feed 7,8 -> out 7,8 with 2-cycle latency.
- len[1]=MAXLEN, feed MAXLEN+3 samples ramp k on ch1 -> first MAXLEN outputs 0, then 0,1,2 (wrap correctness, read-before-write).
- Interleave ch0/ch1 alternately, len0=2, len1=3, ch0 data 100+k, ch1 data 200+k -> ch0 outputs 0,0,100,101; ch1 outputs 0,0,0,200; both with out_ch tags correct.
- Hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, out_* stable, no loss or duplication once released.
- After filling ch2 (len 3), pulse clear on ch2 and feed 9,9,9,9 -> outputs 0,0,0,9. Assert rstn=0 mid-stream -> out_valid drops asynchronously; after release, outputs are 0 until refilled.
